// File: rtl/darkriscv_arb_pkg.sv
// Shared types and constants for the darkriscv fetch/data memory arbiter.
package darkriscv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    D_ACC,
    I_ACC,
    REL
  } arb_state_e;

  localparam int unsigned DLEN_B = 0;
  localparam int unsigned DLEN_H = 1;
  localparam int unsigned DLEN_W = 2;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/darkriscv_lane_ctl.sv
// Byte-enable, store-lane replication and misalignment decode for one data access.
module darkriscv_lane_ctl (
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dlen,
  input  logic [31:0] datao,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);
  import darkriscv_arb_pkg::*;

  logic onehot;

  always_comb begin
    onehot   = $onehot(dlen);
    be       = 4'hF;
    wdata    = datao;
    misalign = |addr_lo;
    // Any size code that is not one-hot falls through to word.
    if (onehot && dlen[DLEN_B]) begin
      be       = 4'b0001 << addr_lo;
      wdata    = {4{datao[7:0]}};
      misalign = 1'b0;
    end else if (onehot && dlen[DLEN_H]) begin
      be       = addr_lo[1] ? 4'b1100 : 4'b0011;
      wdata    = {2{datao[15:0]}};
      misalign = addr_lo[0];
    end
  end

endmodule

// File: rtl/darkriscv_mem_arbiter.sv
// Arbitrates one req/ack memory between darkriscv fetch and data ports; data first, core held via HLT.
module darkriscv_mem_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_INSN = darkriscv_arb_pkg::NOP_INSN,
  parameter logic [31:0] ERR_DATA = darkriscv_arb_pkg::ERR_DATA
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] IADDR,
  output logic [31:0] IDATA,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  input  logic [2:0]  DLEN,
  input  logic        DRD,
  input  logic        DWR,
  output logic [31:0] DATAI,
  output logic        HLT,
  output logic        MREQ,
  output logic        MWE,
  output logic [31:0] MADDR,
  output logic [31:0] MWDATA,
  output logic [3:0]  MBE,
  input  logic [31:0] MRDATA,
  input  logic        MACK,
  output logic        BERR
);
  import darkriscv_arb_pkg::*;

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e        state_q, state_d;
  logic              hlt_q, hlt_d;
  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [3:0]        mbe_q, mbe_d;
  logic [31:0]       maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic [31:0]       idata_q, idata_d;
  logic [31:0]       datai_q, datai_d;
  logic              berr_q, berr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:2]       iaddr_q, iaddr_d;
  logic              drd_q, drd_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        lane_misalign;
  logic        acked, expired, start_fetch;
  logic [31:2] fetch_addr;
  logic        unused_iaddr_lo;

  assign unused_iaddr_lo = ^IADDR[1:0];

  darkriscv_lane_ctl u_lane (
    .addr_lo  (DADDR[1:0]),
    .dlen     (DLEN),
    .datao    (DATAO),
    .be       (lane_be),
    .wdata    (lane_wdata),
    .misalign (lane_misalign)
  );

  always_comb begin
    state_d     = state_q;
    hlt_d       = hlt_q;
    mreq_d      = mreq_q;
    mwe_d       = mwe_q;
    mbe_d       = mbe_q;
    maddr_d     = maddr_q;
    mwdata_d    = mwdata_q;
    idata_d     = idata_q;
    datai_d     = datai_q;
    berr_d      = 1'b0;
    cnt_d       = cnt_q;
    iaddr_d     = iaddr_q;
    drd_d       = drd_q;
    start_fetch = 1'b0;

    acked      = mreq_q && MACK;
    expired    = (TIMEOUT != 0) && mreq_q && !MACK && (cnt_q == CNT_W'(TIMEOUT - 1));
    fetch_addr = (state_q == IDLE) ? IADDR[31:2] : iaddr_q;

    if (mreq_q && !MACK) cnt_d = cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        hlt_d   = 1'b1;
        iaddr_d = IADDR[31:2];
        if ((DRD || DWR) && !lane_misalign) begin
          state_d  = D_ACC;
          mreq_d   = 1'b1;
          mwe_d    = DWR;
          mbe_d    = lane_be;
          mwdata_d = lane_wdata;
          maddr_d  = {DADDR[31:2], 2'b00};
          drd_d    = DRD && !DWR;
          cnt_d    = '0;
        end else begin
          // A misaligned access is reported and skipped; the fetch still goes out.
          if (DRD || DWR) begin
            berr_d = 1'b1;
            if (DRD && !DWR) datai_d = ERR_DATA;
          end
          start_fetch = 1'b1;
        end
      end
      D_ACC: begin
        if (acked || expired) begin
          if (drd_q) datai_d = acked ? MRDATA : ERR_DATA;
          berr_d      = expired;
          start_fetch = 1'b1;
        end
      end
      I_ACC: begin
        if (acked || expired) begin
          idata_d = acked ? MRDATA : NOP_INSN;
          berr_d  = expired;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          hlt_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        hlt_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Fetch is loaded directly into the request registers so it follows a data access with no gap.
    if (start_fetch) begin
      state_d = I_ACC;
      mreq_d  = 1'b1;
      mwe_d   = 1'b0;
      mbe_d   = 4'hF;
      maddr_d = {fetch_addr, 2'b00};
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q  <= IDLE;
      hlt_q    <= 1'b1;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      mbe_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      idata_q  <= '0;
      datai_q  <= '0;
      berr_q   <= 1'b0;
      cnt_q    <= '0;
      iaddr_q  <= '0;
      drd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hlt_q    <= hlt_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      mbe_q    <= mbe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      idata_q  <= idata_d;
      datai_q  <= datai_d;
      berr_q   <= berr_d;
      cnt_q    <= cnt_d;
      iaddr_q  <= iaddr_d;
      drd_q    <= drd_d;
    end
  end

  assign IDATA  = idata_q;
  assign DATAI  = datai_q;
  assign HLT    = hlt_q;
  assign MREQ   = mreq_q;
  assign MWE    = mwe_q;
  assign MADDR  = maddr_q;
  assign MWDATA = mwdata_q;
  assign MBE    = mbe_q;
  assign BERR   = berr_q;

endmodule

// File: tb/tb_darkriscv_mem_arbiter.sv
// Directed bench for darkriscv_mem_arbiter with a read-data scoreboard checked at each HLT release.
module tb_darkriscv_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RES;
  logic [31:0] IADDR, IDATA, DADDR, DATAO, DATAI, MADDR, MWDATA, MRDATA;
  logic [2:0]  DLEN;
  logic        DRD, DWR, HLT, MREQ, MWE, MACK, BERR;
  logic [3:0]  MBE;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  always #5 CLK = ~CLK;

  darkriscv_mem_arbiter #(
    .TIMEOUT  (16),
    .NOP_INSN (32'h0000_0013),
    .ERR_DATA (32'hFFFF_FFFF)
  ) dut (
    .CLK(CLK), .RES(RES), .IADDR(IADDR), .IDATA(IDATA), .DADDR(DADDR), .DATAO(DATAO),
    .DLEN(DLEN), .DRD(DRD), .DWR(DWR), .DATAI(DATAI), .HLT(HLT), .MREQ(MREQ), .MWE(MWE),
    .MADDR(MADDR), .MWDATA(MWDATA), .MBE(MBE), .MRDATA(MRDATA), .MACK(MACK), .BERR(BERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; when the core is released, pop the scoreboard and compare read data.
  task automatic step();
    @(posedge CLK);
    #1;
    if (HLT === 1'b0) begin
      if (iq.size() > 0) chk("idata", IDATA, iq.pop_front());
      if (dq.size() > 0) chk("datai", DATAI, dq.pop_front());
    end
  endtask

  initial begin
    RES = 1'b1; IADDR = '0; DADDR = '0; DATAO = '0; DLEN = 3'b100;
    DRD = 1'b0; DWR = 1'b0; MRDATA = '0; MACK = 1'b0;
    step(); step();
    chk("rst_hlt", HLT, 1);     chk("rst_mreq", MREQ, 0);  chk("rst_mwe", MWE, 0);
    chk("rst_mbe", MBE, 0);     chk("rst_maddr", MADDR, 0); chk("rst_mwdata", MWDATA, 0);
    chk("rst_idata", IDATA, 0); chk("rst_datai", DATAI, 0); chk("rst_berr", BERR, 0);

    // Fetch only, zero-wait memory
    RES = 1'b0; IADDR = 32'h100; MACK = 1'b1; MRDATA = 32'h0050_0093;
    iq.push_back(32'h0050_0093); iq.push_back(32'h0050_0093);
    step();
    chk("f_mreq", MREQ, 1); chk("f_maddr", MADDR, 32'h100); chk("f_mwe", MWE, 0);
    chk("f_mbe", MBE, 4'hF); chk("f_hlt0", HLT, 1);
    for (int k = 1; k < 6; k++) begin
      step();
      chk($sformatf("f_hlt%0d", k), HLT, (k % 3 == 1) ? 0 : 1);
    end

    // Store byte at 0x203, then back-to-back fetch
    DWR = 1'b1; DADDR = 32'h203; DATAO = 32'hAB; DLEN = 3'b001;
    IADDR = 32'h104; MRDATA = 32'h0010_8113; iq.push_back(32'h0010_8113);
    step();
    chk("sb_mreq", MREQ, 1); chk("sb_mwe", MWE, 1); chk("sb_mbe", MBE, 4'b1000);
    chk("sb_mwdata", MWDATA, 32'hABAB_ABAB); chk("sb_maddr", MADDR, 32'h200); chk("sb_hlt1", HLT, 1);
    DWR = 1'b0;
    step();
    chk("sb_f_mreq", MREQ, 1); chk("sb_f_mwe", MWE, 0); chk("sb_f_maddr", MADDR, 32'h104);
    chk("sb_hlt2", HLT, 1);
    step();
    chk("sb_hlt3", HLT, 0);
    step();
    chk("sb_hlt4", HLT, 1);

    // Load half at 0x402 with three wait cycles
    DRD = 1'b1; DADDR = 32'h402; DLEN = 3'b010; IADDR = 32'h108; MACK = 1'b0;
    step();
    chk("lh_mreq", MREQ, 1); chk("lh_mwe", MWE, 0); chk("lh_mbe", MBE, 4'b1100);
    chk("lh_maddr", MADDR, 32'h400);
    DRD = 1'b0;
    for (int w = 0; w < 3; w++) begin
      step();
      chk("lh_wait_mreq", MREQ, 1); chk("lh_wait_maddr", MADDR, 32'h400);
      chk("lh_wait_mbe", MBE, 4'b1100); chk("lh_wait_hlt", HLT, 1);
    end
    MACK = 1'b1; MRDATA = 32'h1234_5678; dq.push_back(32'h1234_5678);
    step();
    chk("lh_f_mreq", MREQ, 1); chk("lh_f_maddr", MADDR, 32'h108);
    MRDATA = 32'h0021_0213; iq.push_back(32'h0021_0213);
    step();
    chk("lh_hlt", HLT, 0);
    step();

    // Misaligned word load at 0x401
    DRD = 1'b1; DADDR = 32'h401; DLEN = 3'b100; IADDR = 32'h10C; MRDATA = 32'h0031_8193;
    dq.push_back(32'hFFFF_FFFF); iq.push_back(32'h0031_8193);
    step();
    chk("mis_berr", BERR, 1); chk("mis_maddr", MADDR, 32'h10C); chk("mis_mwe", MWE, 0);
    chk("mis_mreq", MREQ, 1);
    DRD = 1'b0;
    step();
    chk("mis_berr_clr", BERR, 0); chk("mis_hlt", HLT, 0);
    step();

    // Fetch timeout with MACK never asserted
    MACK = 1'b0; IADDR = 32'h110; iq.push_back(32'h0000_0013);
    step();
    chk("to_mreq0", MREQ, 1);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_mreq", MREQ, 1); chk("to_berr_lo", BERR, 0);
    end
    step();
    chk("to_mreq_drop", MREQ, 0); chk("to_berr", BERR, 1); chk("to_hlt", HLT, 0);
    step();
    chk("to_berr_clr", BERR, 0); chk("to_hlt_back", HLT, 1);

    // Reset during the second wait cycle of a store
    DWR = 1'b1; DADDR = 32'h300; DATAO = 32'hDEAD_BEEF; DLEN = 3'b100; IADDR = 32'h114;
    step();
    chk("rs_mwe", MWE, 1); chk("rs_mbe", MBE, 4'hF); chk("rs_mwdata", MWDATA, 32'hDEAD_BEEF);
    chk("rs_maddr", MADDR, 32'h300);
    DWR = 1'b0;
    step();
    RES = 1'b1;
    step();
    chk("rs_mreq", MREQ, 0); chk("rs_hlt", HLT, 1); chk("rs_maddr0", MADDR, 0);
    chk("rs_mbe0", MBE, 0); chk("rs_idata", IDATA, 0); chk("rs_datai", DATAI, 0);
    RES = 1'b0; MACK = 1'b1; MRDATA = 32'h0042_0213; iq.push_back(32'h0042_0213);
    step();
    chk("rs_f_mreq", MREQ, 1); chk("rs_f_maddr", MADDR, 32'h114);
    step();
    chk("rs_f_hlt", HLT, 0);
    step();

    // DRD and DWR together with a non-one-hot size: word store, DATAI untouched
    DRD = 1'b1; DWR = 1'b1; DADDR = 32'h500; DLEN = 3'b011; DATAO = 32'h1122_3344;
    IADDR = 32'h118; MRDATA = 32'h0053_0293; dq.push_back(32'h0); iq.push_back(32'h0053_0293);
    step();
    chk("rw_mwe", MWE, 1); chk("rw_mbe", MBE, 4'hF); chk("rw_mwdata", MWDATA, 32'h1122_3344);
    chk("rw_maddr", MADDR, 32'h500);
    DRD = 1'b0; DWR = 1'b0;
    step(); step(); step();

    // Half store to the upper lanes
    DWR = 1'b1; DADDR = 32'h506; DLEN = 3'b010; DATAO = 32'hCAFE_BEEF;
    IADDR = 32'h11C; MRDATA = 32'h0000_0073; iq.push_back(32'h0000_0073);
    step();
    chk("sh_mbe", MBE, 4'b1100); chk("sh_mwdata", MWDATA, 32'hBEEF_BEEF);
    chk("sh_maddr", MADDR, 32'h504); chk("sh_mwe", MWE, 1);
    DWR = 1'b0;
    step(); step();
    chk("sh_hlt", HLT, 0);
    step();

    chk("sb_drained", iq.size() + dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/darkriscv_mem_arbiter.md
Name: darkriscv_mem_arbiter

Overview:
- Shares one single-port memory between the darkriscv instruction-fetch port and data port, stalling the core through HLT while accesses are in flight.
- Sits between the core (IADDR/IDATA, DADDR/DATAI/DATAO/DLEN/DRD/DWR) and a req/ack memory.
- Data access always wins over fetch, because it belongs to the older instruction.
- Generates byte enables and write-lane replication, flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16: cycles to wait for MACK before aborting an access; 0 disables the timeout.
- NOP_INSN, 32'h0000_0013: instruction returned on a fetch timeout.
- ERR_DATA, 32'hFFFF_FFFF: read data returned on a data timeout or misaligned read.

Ports:
- CLK  in  1  Clock; one clock domain. Reset is synchronous and active-high.
- RES  in  1  Synchronous, active-high reset.
- IADDR  in  32  Fetch address from the core.
- IDATA  out  32  Fetched instruction, registered.
- DADDR  in  32  Data address.
- DATAO  in  32  Store data; the byte/half value is in the low lanes.
- DLEN  in  3  One-hot size: [0]=byte, [1]=half, [2]=word.
- DRD  in  1  Load request.
- DWR  in  1  Store request.
- DATAI  out  32  Raw 32-bit memory word for loads, registered. The core extracts the lane.
- HLT  out  1  Core stall.
- MREQ  out  1  Memory request.
- MWE  out  1  Memory write enable.
- MADDR  out  32  Word address: {addr[31:2],2'b00}.
- MWDATA  out  32  Lane-replicated write data.
- MBE  out  4  Byte enables.
- MRDATA  in  32  Memory read data, valid with MACK.
- MACK  in  1  Memory acknowledge.
- BERR  out  1  One-cycle pulse on timeout or misaligned access.

Behaviour:
- Reset values: state=IDLE, HLT=1, MREQ=0, MWE=0, MBE=0, MADDR=0, MWDATA=0, IDATA=0, DATAI=0, BERR=0, timeout counter=0.
- FSM states: IDLE, D_ACC, I_ACC, REL. All outputs are registered.
- IDLE (HLT=1): sample DRD/DWR/DADDR/DLEN/DATAO/IADDR.
  - DRD|DWR with a legal alignment: go to D_ACC with MREQ=1, MWE=DWR.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): no memory access. Pulse BERR; if DRD, DATAI=ERR_DATA. Go to I_ACC.
  - No data request: go to I_ACC with MREQ=1, MWE=0, MBE=4'hF, MADDR from IADDR.
  - DRD and DWR both high: treat as a store; DATAI is unchanged.
- D_ACC (HLT=1): MREQ, MADDR, MWE, MBE and MWDATA stay stable until MACK is sampled high.
  - On MACK: if read, DATAI<=MRDATA. Next state is I_ACC with MREQ kept at 1 and the fetch address/controls loaded (back-to-back, no idle gap).
- I_ACC (HLT=1): on MACK, IDATA<=MRDATA, MREQ<=0, go to REL.
- REL: HLT=0 for exactly one cycle so the core advances; then back to IDLE.
- Latency with a zero-wait memory (MACK in the first MREQ cycle):
  - Fetch only: 3 cycles per instruction, HLT low 1 of 3.
  - With a data access: 4 cycles.
- Lane rules:
  - byte: MBE=4'b0001<<addr[1:0], MWDATA={4{DATAO[7:0]}}.
  - half: MBE=addr[1]?4'b1100:4'b0011, MWDATA={2{DATAO[15:0]}}.
  - word: MBE=4'hF, MWDATA=DATAO.
  - Reads use the same MBE as a write of that size would.
  - DLEN not one-hot while DRD|DWR: treat as word.
- Timeout: the counter resets on entry to D_ACC/I_ACC and increments each cycle MREQ=1 && !MACK.
  - When the count reaches TIMEOUT-1 with no MACK: MREQ<=0 and BERR pulses.
  - Fetch timeout: IDATA=NOP_INSN. Data-read timeout: DATAI=ERR_DATA. Data-write timeout: the write is dropped.
  - The FSM then continues as if MACK had arrived.
  - MACK arriving in the same cycle as expiry counts as success; no BERR.
- MACK while MREQ=0 is ignored.
- RES mid-access: next edge goes to IDLE with MREQ=0. The memory must tolerate an abandoned request. IDATA/DATAI return to 0.

Decomposition:
- Package darkriscv_arb_pkg holds:
  - the state enum {IDLE,D_ACC,I_ACC,REL}
  - DLEN bit indices (DLEN_B=0, DLEN_H=1, DLEN_W=2)
  - default constants NOP_INSN and ERR_DATA
- Sub-module darkriscv_lane_ctl (combinational): DADDR[1:0], DLEN, DATAO -> MBE, MWDATA, misalign flag.
- The arbiter registers the sub-module's outputs.

Test Plan:
- Fetch only, IADDR=0x100, MACK same cycle, MRDATA=0x00500093 -> IDATA=0x00500093; HLT pattern 1,1,0 repeating; MADDR=0x100, MWE=0.
- Store byte DADDR=0x203, DATAO=0xAB, then fetch, zero-wait memory -> first access MBE=4'b1000, MWDATA=0xABABABAB, MWE=1; fetch follows back-to-back with MREQ held high; HLT low after 4 cycles.
- Load half DADDR=0x402, MACK after 3 wait cycles, MRDATA=0x12345678 -> MBE=4'b1100, DATAI=0x12345678, MREQ/MADDR stable during the waits.
- Load word DADDR=0x401 -> no MREQ for the data access, BERR pulses once, DATAI=0xFFFFFFFF, fetch still issued.
- TIMEOUT=16, MACK never asserted on a fetch -> MREQ drops after 16 cycles, BERR pulses, IDATA=0x00000013, HLT low one cycle later.
- RES asserted in the 2nd wait cycle of a store -> next edge MREQ=0, HLT=1, state IDLE; normal fetch resumes after RES is released.
